// File: rtl/sad_stream_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : sad_stream_engine_if
// Description : Handshake/bus bundle for sad_stream_engine.
//               Pixel-beat input channel (init, in_valid/in_ready, in_last,
//               ori, can) and held result channel (out_valid/out_ack,
//               out_sad, out_idx, out_frame_done, out_best_sad,
//               out_best_idx).
//               master : the side that streams pixels and consumes results
//               slave  : the SAD engine
// Revision    : 1.0 - initial release
// ============================================================================
interface sad_stream_engine_if #(
    parameter int WIDTH        = 8,
    parameter int LANES        = 4,
    parameter int BLOCK_PIXELS = 64,
    parameter int IDX_W        = 8
);
    localparam int SUM_W = WIDTH + $clog2(BLOCK_PIXELS) + 1;

    logic                   init;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [LANES*WIDTH-1:0] ori;
    logic [LANES*WIDTH-1:0] can;
    logic                   out_valid;
    logic                   out_ack;
    logic [SUM_W-1:0]       out_sad;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_frame_done;
    logic [SUM_W-1:0]       out_best_sad;
    logic [IDX_W-1:0]       out_best_idx;

    modport master (
        output init, in_valid, in_last, ori, can, out_ack,
        input  in_ready, out_valid, out_sad, out_idx, out_frame_done,
               out_best_sad, out_best_idx
    );

    modport slave (
        input  init, in_valid, in_last, ori, can, out_ack,
        output in_ready, out_valid, out_sad, out_idx, out_frame_done,
               out_best_sad, out_best_idx
    );
endinterface
`default_nettype wire

// File: rtl/sad_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : sad_stream_engine
// Description : Streaming Sum-of-Absolute-Differences engine. Accumulates
//               |ori - can| over LANES pixels per beat for BLOCK_PIXELS
//               pixels per candidate, then holds the candidate's SAD and
//               index on the result channel until acknowledged.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - sad_stream_engine_if.slave (pixel and result channels)
// Options     : SAD_BEST_MATCH_EN - when defined, tracks the minimum SAD of
//               the frame and its index on out_best_sad/out_best_idx;
//               otherwise those outputs are tied to all-ones / zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_stream_engine #(
    parameter int WIDTH        = 8,
    parameter int LANES        = 4,
    parameter int BLOCK_PIXELS = 64,
    parameter int IDX_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    sad_stream_engine_if.slave  bus
);
    localparam int BEATS = BLOCK_PIXELS / LANES;
    localparam int SUM_W = WIDTH + $clog2(BLOCK_PIXELS) + 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACC    = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUM_W-1:0] sad_q, sad_d;
    logic [IDX_W-1:0] oidx_q, oidx_d;
    logic             fdone_q, fdone_d;

    // Per-lane absolute difference; each fits in WIDTH bits.
    logic [WIDTH-1:0] w_diff [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] w_o;
        logic [WIDTH-1:0] w_c;
        assign w_o       = bus.ori[k*WIDTH +: WIDTH];
        assign w_c       = bus.can[k*WIDTH +: WIDTH];
        assign w_diff[k] = (w_o >= w_c) ? (w_o - w_c) : (w_c - w_o);
    end

    logic [SUM_W-1:0] w_beat_sad;
    always_comb begin
        w_beat_sad = '0;
        for (int k = 0; k < LANES; k++) begin
            w_beat_sad = w_beat_sad + SUM_W'(w_diff[k]);
        end
    end

    logic             w_beat;
    logic             w_final_beat;
    logic [SUM_W-1:0] w_sum;

    assign w_beat       = (state_q == S_ACC) && bus.in_valid;
    assign w_final_beat = w_beat && (cnt_q == C_LAST);
    assign w_sum        = acc_q + w_beat_sad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sad_d   = sad_q;
        oidx_d  = oidx_q;
        fdone_d = fdone_q;
        case (state_q)
            S_IDLE: begin
                if (bus.init) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (w_beat) begin
                    acc_d = w_sum;
                    if (w_final_beat) begin
                        sad_d   = w_sum;
                        oidx_d  = idx_q;
                        // in_last only matters on the block's final beat.
                        fdone_d = bus.in_last;
                        state_d = S_RESULT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RESULT: begin
                if (bus.out_ack) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = fdone_q ? S_IDLE : S_ACC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            sad_q   <= '0;
            oidx_q  <= '0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sad_q   <= sad_d;
            oidx_q  <= oidx_d;
            fdone_q <= fdone_d;
        end
    end

    assign bus.in_ready       = (state_q == S_ACC);
    assign bus.out_valid      = (state_q == S_RESULT);
    assign bus.out_sad        = sad_q;
    assign bus.out_idx        = oidx_q;
    assign bus.out_frame_done = fdone_q;

`ifdef SAD_BEST_MATCH_EN
    logic [SUM_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    // Strict less-than: on a tie the earlier candidate keeps the title.
    always_comb begin
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        if ((state_q == S_IDLE) && bus.init) begin
            best_sad_d = '1;
            best_idx_d = '0;
        end else if (w_final_beat && (w_sum < best_sad_q)) begin
            best_sad_d = w_sum;
            best_idx_d = idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_sad_q <= '1;
            best_idx_q <= '0;
        end else begin
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign bus.out_best_sad = best_sad_q;
    assign bus.out_best_idx = best_idx_q;
`else
    assign bus.out_best_sad = '1;
    assign bus.out_best_idx = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sad_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_stream_engine
// Description : Self-checking bench for sad_stream_engine. Random pixel
//               blocks and handshake gaps; expected SADs come from a
//               pixel-level reference sum. Inputs are driven and outputs
//               sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_stream_engine;
    localparam int WIDTH        = 8;
    localparam int LANES        = 4;
    localparam int BLOCK_PIXELS = 64;
    localparam int IDX_W        = 8;
    localparam int BEATS        = BLOCK_PIXELS / LANES;
    localparam int SUM_W        = WIDTH + $clog2(BLOCK_PIXELS) + 1;
    localparam longint ALL_ONES = (64'd1 << SUM_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sad_stream_engine_if #(
        .WIDTH(WIDTH), .LANES(LANES), .BLOCK_PIXELS(BLOCK_PIXELS), .IDX_W(IDX_W)
    ) bus ();

    sad_stream_engine #(
        .WIDTH(WIDTH), .LANES(LANES), .BLOCK_PIXELS(BLOCK_PIXELS), .IDX_W(IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int     px_o [BLOCK_PIXELS];
    int     px_c [BLOCK_PIXELS];
    longint blk_sad;
    longint held_sad;
    bit     held_last;
    int     exp_idx;
    longint best_sad;
    int     best_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: random, 1: ori=255/can=0, 2: identical, 3: SAD equals target
    task automatic make_block(input int mode, input int target);
        int rem;
        rem = target;
        for (int p = 0; p < BLOCK_PIXELS; p++) begin
            case (mode)
                0: begin px_o[p] = $urandom_range(255); px_c[p] = $urandom_range(255); end
                1: begin px_o[p] = 255; px_c[p] = 0; end
                2: begin px_o[p] = $urandom_range(255); px_c[p] = px_o[p]; end
                default: begin
                    px_o[p] = 0;
                    px_c[p] = (rem > 255) ? 255 : rem;
                    rem     = rem - px_c[p];
                end
            endcase
        end
        blk_sad = 0;
        for (int p = 0; p < BLOCK_PIXELS; p++)
            blk_sad += (px_o[p] > px_c[p]) ? (px_o[p] - px_c[p]) : (px_c[p] - px_o[p]);
    endtask

    // Called and returns at a falling edge.
    task automatic do_init();
        bus.init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.init = 1'b0;
        exp_idx  = 0;
        best_sad = ALL_ONES;
        best_idx = 0;
        check("init_ready", bus.in_ready, 1);
    endtask

    task automatic feed(input int n_beats, input int gap_pct, input bit last);
        int b;
        int guard;
        bit go;
        b = 0;
        guard = 0;
        while (b < n_beats && guard < 2000) begin
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            for (int k = 0; k < LANES; k++) begin
                bus.ori[k*WIDTH +: WIDTH] = WIDTH'(px_o[b*LANES + k]);
                bus.can[k*WIDTH +: WIDTH] = WIDTH'(px_c[b*LANES + k]);
            end
            bus.in_last = (b == BEATS - 1) ? last : 1'($urandom_range(1));
            go = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (go) b++;
            guard++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (guard >= 2000) check("feed_timeout_beats", b, n_beats);
    endtask

    task automatic check_result(input bit last);
        held_sad  = blk_sad;
        held_last = last;
`ifdef SAD_BEST_MATCH_EN
        if (blk_sad < best_sad) begin
            best_sad = blk_sad;
            best_idx = exp_idx;
        end
`endif
        check("res_valid", bus.out_valid, 1);
        check("res_sad", bus.out_sad, held_sad);
        check("res_idx", bus.out_idx, exp_idx);
        check("res_fdone", bus.out_frame_done, last);
        check("res_ready", bus.in_ready, 0);
        check("res_best_sad", bus.out_best_sad, best_sad);
        check("res_best_idx", bus.out_best_idx, best_idx);
    endtask

    // Hold ack low for 'hold' cycles (optionally with in_valid/init noise),
    // then acknowledge.
    task automatic ack(input int hold, input bit noise);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = noise;
            bus.init     = noise && (i == 3);
            check("hold_valid", bus.out_valid, 1);
            check("hold_sad", bus.out_sad, held_sad);
            check("hold_idx", bus.out_idx, exp_idx);
            check("hold_ready", bus.in_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.init     = 1'b0;
        bus.out_ack  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ack = 1'b0;
        exp_idx = (exp_idx + 1) % (1 << IDX_W);
        check("ack_valid_low", bus.out_valid, 0);
        check("ack_ready", bus.in_ready, !held_last);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_sad"}, bus.out_sad, 0);
        check({tag, "_out_idx"}, bus.out_idx, 0);
        check({tag, "_fdone"}, bus.out_frame_done, 0);
        check({tag, "_best_sad"}, bus.out_best_sad, ALL_ONES);
        check({tag, "_best_idx"}, bus.out_best_idx, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint c0;
        int     ncand;
        bus.init = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.ori = '0; bus.can = '0; bus.out_ack = 1'b0;
        exp_idx = 0; best_sad = ALL_ONES; best_idx = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // Max-difference block, no gaps: latency and full-scale sum.
        make_block(1, 0);
        c0 = cyc;
        do_init();
        feed(BEATS, 0, 1'b0);
        check("lat_init_to_valid", cyc - c0, 17);
        check("max_sad_16320", bus.out_sad, 16320);
        check_result(1'b0);
        ack(0, 1'b0);

        // Identical block closing the frame.
        make_block(2, 0);
        feed(BEATS, 0, 1'b1);
        check_result(1'b1);
        ack(2, 1'b0);
        @(negedge clk);
        check("idle_ready", bus.in_ready, 0);

        // Random data with 50% valid gaps.
        do_init();
        for (int c = 0; c < 2; c++) begin
            make_block(0, 0);
            feed(BEATS, 50, c == 1);
            check_result(c == 1);
            ack(1, 1'b0);
        end

        // Best-match sequence 500, 120, 120.
        do_init();
        make_block(3, 500); feed(BEATS, 20, 1'b0); check_result(1'b0); ack(0, 1'b0);
        make_block(3, 120); feed(BEATS, 20, 1'b0); check_result(1'b0); ack(0, 1'b0);
        make_block(3, 120); feed(BEATS, 20, 1'b1); check_result(1'b1);
`ifdef SAD_BEST_MATCH_EN
        check("best_final_sad", bus.out_best_sad, 120);
        check("best_final_idx", bus.out_best_idx, 1);
`endif
        ack(0, 1'b0);

        // Reset in the middle of a block discards the partial sum.
        do_init();
        make_block(0, 0);
        feed(7, 0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst_hold");
        rst = 1'b0;
        @(negedge clk);
        do_init();
        make_block(0, 0);
        feed(BEATS, 30, 1'b0);
        check_result(1'b0);

        // Held result with in_valid and init noise.
        ack(10, 1'b1);
        make_block(0, 0);
        feed(BEATS, 0, 1'b1);
        check_result(1'b1);
        ack(0, 1'b0);

        // Random frames.
        for (int f = 0; f < 2; f++) begin
            do_init();
            ncand = $urandom_range(1, 3);
            for (int c = 0; c < ncand; c++) begin
                make_block(0, 0);
                feed(BEATS, $urandom_range(0, 60), c == ncand - 1);
                check_result(c == ncand - 1);
                ack($urandom_range(0, 3), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
